// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging N_REQUESTERS valid/ready input streams into one
// registered output stream. The requester after the last grant has priority,
// wrapping around. A word entering the output register appears one cycle after
// its input transfer. The register reloads in the same cycle it drains, so the
// block sustains one word per cycle.
module stream_rr_arbiter #(
  parameter int N_REQUESTERS = 4,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQUESTERS-1:0]              in_valid,
  input  logic [N_REQUESTERS*DATA_WIDTH-1:0]   in_data,
  output logic [N_REQUESTERS-1:0]              in_ready,
  output logic                                 out_valid,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [$clog2(N_REQUESTERS)-1:0]      out_source,
  input  logic                                 out_ready
);

  localparam int SW = $clog2(N_REQUESTERS);
  localparam logic [SW-1:0] LAST_IDX = SW'(N_REQUESTERS - 1);

  logic [SW-1:0]                               last_grant;
  logic [SW-1:0]                               cand;
  logic                                        found;
  logic                                        free;
  logic [N_REQUESTERS-1:0][DATA_WIDTH-1:0]     words;

  // View the flat input bus as one word per requester.
  assign words = in_data;

  // The output register can accept a word when it is empty or draining now.
  assign free = !out_valid || out_ready;

  // Candidate search. First pass: the lowest valid index, which is the
  // wrap-around fallback. Second pass: the lowest valid index above
  // last_grant, which overrides the fallback when one exists.
  always_comb begin
    cand  = '0;
    found = 1'b0;
    for (int i = N_REQUESTERS - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        found = 1'b1;
        cand  = SW'(i);
      end
    end
    for (int i = N_REQUESTERS - 1; i >= 0; i--) begin
      if (in_valid[i] && (SW'(i) > last_grant)) cand = SW'(i);
    end
  end

  // Grant only the candidate, only when the register is free, never in reset.
  always_comb begin
    in_ready = '0;
    if (!rst && found && free) in_ready[cand] = 1'b1;
  end

  // Output register and grant pointer. A grant loads the register. A free
  // register with no grant empties, and its data and source hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_source <= '0;
      last_grant <= LAST_IDX;
    end else if (free) begin
      if (found) begin
        out_valid  <= 1'b1;
        out_data   <= words[cand];
        out_source <= cand;
        last_grant <= cand;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter. A reference model predicts each grant.
// The expected word is pushed to a queue when its input transfer occurs, and it
// is popped and compared when the output transfer occurs.
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      in_valid = '0;
  logic [N*DW-1:0]   in_data = '0;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_source;
  logic              out_ready = 1'b0;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  bit           m_valid = 1'b0;
  int           m_lg = N - 1;
  logic [N-1:0] last_ready;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.N_REQUESTERS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_source(out_source), .out_ready(out_ready)
  );

  // Reference round robin: step from lg+1 with modular wrap. Returns -1 if idle.
  function automatic int pick(input logic [N-1:0] v, input int lg);
    for (int k = 1; k <= N; k++) begin
      int idx = (lg + k) % N;
      if (v[idx[SW-1:0]]) return idx;
    end
    return -1;
  endfunction

  // One clock. Inputs are already driven just after the negedge. Check the
  // outputs, advance the model, then move on to the next negedge.
  task automatic tick();
    int   g;
    bit   free;
    logic [N-1:0] exp_rdy;
    exp_t e;
    #1;
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL out_valid: got %b want %b at %0t", out_valid, m_valid, $time);
    end
    if (!rst && m_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: output transfer with empty scoreboard at %0t", $time);
      end else begin
        e = q.pop_front();
        if (out_data !== e.d || out_source !== e.s) begin
          errors++;
          $display("FAIL sb_word: got %h/%0d want %h/%0d at %0t",
                   out_data, out_source, e.d, e.s, $time);
        end
      end
    end
    free = !m_valid || out_ready;
    g = pick(in_valid, m_lg);
    exp_rdy = '0;
    if (!rst && free && g >= 0) exp_rdy[g[SW-1:0]] = 1'b1;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b want %b at %0t", in_ready, exp_rdy, $time);
    end
    last_ready = in_ready;
    if (rst) begin
      q.delete();
      m_valid = 1'b0;
      m_lg = N - 1;
    end else if (free) begin
      if (g >= 0) begin
        e.d = in_data[g*DW +: DW];
        e.s = g[SW-1:0];
        q.push_back(e);
        m_lg = g;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_words(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = base + DW'(i);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '1; out_ready = 1'b1; set_words(8'hA0);
    tick();
    tick();
    checks++;
    if (last_ready !== '0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", last_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_source !== '0) begin
      errors++;
      $display("FAIL reset_regs: got v=%b d=%h s=%0d want 0/00/0", out_valid, out_data, out_source);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (last_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_first_grant: got %b want 0001", last_ready);
    end
  endtask

  task automatic test_round_robin();
    int exp_src[5] = '{0, 1, 2, 3, 0};
    do_reset();
    in_valid = '1; out_ready = 1'b1; set_words(8'hA0);
    tick();
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA0 + DW'(exp_src[j]) ||
          out_source !== SW'(exp_src[j])) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got v=%b %h/%0d want 1 %h/%0d", j, out_valid,
                 out_data, out_source, 8'hA0 + DW'(exp_src[j]), exp_src[j]);
      end
      tick();
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1; set_words(8'h10);
    in_valid = 4'b0100;
    tick();
    in_valid = 4'b0011;
    tick();
    checks++;
    if (last_ready !== 4'b0001) begin
      errors++; $display("FAIL wrap_grant0: got %b want 0001", last_ready);
    end
    tick();
    checks++;
    if (last_ready !== 4'b0010) begin
      errors++; $display("FAIL wrap_grant1: got %b want 0010", last_ready);
    end
    checks++;
    if (out_source !== 2'd1 || out_data !== 8'h11) begin
      errors++; $display("FAIL wrap_out: got %h/%0d want 11/1", out_data, out_source);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1; in_valid = 4'b0001; in_data[0 +: DW] = 8'h55;
    tick();
    in_valid = 4'b0010; in_data[DW +: DW] = 8'h66; out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h55 || last_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h rdy=%b want 1 55 0000", j,
                 out_valid, out_data, last_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (last_ready !== 4'b0010 || out_data !== 8'h66 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b d=%h v=%b want 0010 66 1", last_ready, out_data, out_valid);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; in_valid = 4'b0001; in_data[0 +: DW] = 8'h77;
    tick();
    in_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77) begin
      errors++; $display("FAIL mid_loaded: got v=%b d=%h want 1 77", out_valid, out_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_discard: got out_valid %b want 0", out_valid);
    end
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'($urandom);
      tick();
    end
    in_valid = '0; out_ready = 1'b1;
    for (int c = 0; c < 8 && (q.size() > 0 || m_valid); c++) tick();
    checks++;
    if (q.size() != 0 || m_valid) begin
      errors++; $display("FAIL watchdog_drain: %0d words left want 0", q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
